// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life generation controller:
// neighbour count, default rule masks and the controller state type.
package life_pkg;

    localparam int NEIGHBOURS_CNT = 8;
    localparam int CNT_W = $clog2(NEIGHBOURS_CNT + 1);

    // Conway B3/S23
    localparam logic [NEIGHBOURS_CNT:0] BIRTH_MASK_DEF   = 9'b000001000;
    localparam logic [NEIGHBOURS_CNT:0] SURVIVE_MASK_DEF = 9'b000001100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_FLUSH = 3'd3,
        ST_SWAP  = 3'd4
    } state_e;

endpackage

// File: rtl/life_rule.sv
// Cell rule: popcount of the 8 neighbours, then birth/survive mask lookup.
// Ports: i_cell (cell state), i_nbrs (neighbours), o_next (next state).
module life_rule
    import life_pkg::*;
#(
    parameter logic [NEIGHBOURS_CNT:0] BIRTH_MASK   = BIRTH_MASK_DEF,
    parameter logic [NEIGHBOURS_CNT:0] SURVIVE_MASK = SURVIVE_MASK_DEF
) (
    input  logic                      i_cell,
    input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
    output logic                      o_next
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
            cnt = cnt + CNT_W'(i_nbrs[i]);
        end
        o_next = i_cell ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
    end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation controller: raster sweep of the current bank, registered
// write of next states into the other bank, bank swap, edit service.
// Ports: clk/rst_n, i_step/i_run starts, i_edit_* edit request with
// o_edit_ack, o_cur_* / i_cur_* current-bank port 1, o_nxt_* next-bank
// write port, o_bank_sel, o_busy, o_gen_done pulse, o_gen_cnt.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 32,
    parameter logic [NEIGHBOURS_CNT:0] BIRTH_MASK   = BIRTH_MASK_DEF,
    parameter logic [NEIGHBOURS_CNT:0] SURVIVE_MASK = SURVIVE_MASK_DEF,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_step,
    input  logic                      i_run,
    input  logic                      i_edit_req,
    input  logic [X_ADR_SIZE-1:0]     i_edit_x,
    input  logic [Y_ADR_SIZE-1:0]     i_edit_y,
    input  logic                      i_edit_val,
    output logic                      o_edit_ack,
    output logic [X_ADR_SIZE-1:0]     o_cur_x,
    output logic [Y_ADR_SIZE-1:0]     o_cur_y,
    output logic                      o_cur_w_en,
    output logic                      o_cur_w_data,
    input  logic                      i_cur_cell,
    input  logic [NEIGHBOURS_CNT-1:0] i_cur_nbrs,
    output logic [X_ADR_SIZE-1:0]     o_nxt_x,
    output logic [Y_ADR_SIZE-1:0]     o_nxt_y,
    output logic                      o_nxt_w_en,
    output logic                      o_nxt_w_data,
    output logic                      o_bank_sel,
    output logic                      o_busy,
    output logic                      o_gen_done,
    output logic [15:0]               o_gen_cnt
);

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    state_e                state;
    state_e                state_d;
    logic [X_ADR_SIZE-1:0] scan_x;
    logic [Y_ADR_SIZE-1:0] scan_y;
    logic                  x_last;
    logic                  y_last;
    logic                  cell_next;

    assign x_last = (scan_x == X_LAST);
    assign y_last = (scan_y == Y_LAST);

    life_rule #(
        .BIRTH_MASK   (BIRTH_MASK),
        .SURVIVE_MASK (SURVIVE_MASK)
    ) u_rule (
        .i_cell (i_cur_cell),
        .i_nbrs (i_cur_nbrs),
        .o_next (cell_next)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (i_step || i_run) begin
                    state_d = ST_SWEEP;
                end else if (i_edit_req) begin
                    state_d = ST_EDIT;
                end
            end
            ST_EDIT:  state_d = ST_IDLE;
            ST_SWEEP: if (x_last && y_last) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_SWAP;
            ST_SWAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Scan address is held at (0,0) outside SWEEP, so a start from
    // IDLE always begins at the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            scan_x <= '0;
            scan_y <= '0;
        end else begin
            state <= state_d;
            if (state == ST_SWEEP) begin
                scan_x <= x_last ? '0 : scan_x + X_ADR_SIZE'(1);
                if (x_last) begin
                    scan_y <= y_last ? '0 : scan_y + Y_ADR_SIZE'(1);
                end
            end else begin
                scan_x <= '0;
                scan_y <= '0;
            end
        end
    end

    // Write stage: one cycle behind the read, so the last cell's
    // write lands in FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_nxt_x      <= '0;
            o_nxt_y      <= '0;
            o_nxt_w_en   <= 1'b0;
            o_nxt_w_data <= 1'b0;
        end else begin
            o_nxt_x      <= scan_x;
            o_nxt_y      <= scan_y;
            o_nxt_w_en   <= (state == ST_SWEEP);
            o_nxt_w_data <= cell_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bank_sel <= 1'b0;
            o_gen_cnt  <= '0;
        end else if (state == ST_SWAP) begin
            o_bank_sel <= ~o_bank_sel;
            o_gen_cnt  <= o_gen_cnt + 16'd1;
        end
    end

    always_comb begin
        o_cur_x      = '0;
        o_cur_y      = '0;
        o_cur_w_en   = 1'b0;
        o_cur_w_data = 1'b0;
        unique case (1'b1)
            (state == ST_EDIT): begin
                o_cur_x      = i_edit_x;
                o_cur_y      = i_edit_y;
                o_cur_w_en   = 1'b1;
                o_cur_w_data = i_edit_val;
            end
            (state == ST_SWEEP): begin
                o_cur_x = scan_x;
                o_cur_y = scan_y;
            end
            default: ;
        endcase
    end

    assign o_edit_ack = (state == ST_EDIT);
    assign o_gen_done = (state == ST_SWAP);
    assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl on an 8x8 toroidal field: two bank models
// steered by o_bank_sel, checked against a whole-field reference step.
module tb_life_gen_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NC = W * H;
    localparam logic [8:0] BM = 9'b000001000;
    localparam logic [8:0] SM = 9'b000001100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_step = 1'b0;
    logic       i_run = 1'b0;
    logic       i_edit_req = 1'b0;
    logic [2:0] i_edit_x = '0;
    logic [2:0] i_edit_y = '0;
    logic       i_edit_val = 1'b0;
    logic       o_edit_ack;
    logic [2:0] o_cur_x;
    logic [2:0] o_cur_y;
    logic       o_cur_w_en;
    logic       o_cur_w_data;
    logic       i_cur_cell;
    logic [7:0] i_cur_nbrs;
    logic [2:0] o_nxt_x;
    logic [2:0] o_nxt_y;
    logic       o_nxt_w_en;
    logic       o_nxt_w_data;
    logic       o_bank_sel;
    logic       o_busy;
    logic       o_gen_done;
    logic [15:0] o_gen_cnt;

    life_gen_ctrl #(.FIELD_W(W), .FIELD_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .i_step(i_step), .i_run(i_run),
        .i_edit_req(i_edit_req), .i_edit_x(i_edit_x),
        .i_edit_y(i_edit_y), .i_edit_val(i_edit_val),
        .o_edit_ack(o_edit_ack), .o_cur_x(o_cur_x), .o_cur_y(o_cur_y),
        .o_cur_w_en(o_cur_w_en), .o_cur_w_data(o_cur_w_data),
        .i_cur_cell(i_cur_cell), .i_cur_nbrs(i_cur_nbrs),
        .o_nxt_x(o_nxt_x), .o_nxt_y(o_nxt_y), .o_nxt_w_en(o_nxt_w_en),
        .o_nxt_w_data(o_nxt_w_data), .o_bank_sel(o_bank_sel),
        .o_busy(o_busy), .o_gen_done(o_gen_done), .o_gen_cnt(o_gen_cnt)
    );

    always #5 clk = ~clk;

    // Field banks (environment), cleared by their own reset
    logic mem [2][NC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                mem[0][i] <= 1'b0;
                mem[1][i] <= 1'b0;
            end
        end else begin
            if (o_cur_w_en)
                mem[o_bank_sel][int'(o_cur_y) * W + int'(o_cur_x)] <= o_cur_w_data;
            if (o_nxt_w_en)
                mem[!o_bank_sel][int'(o_nxt_y) * W + int'(o_nxt_x)] <= o_nxt_w_data;
        end
    end

    int cx, cy, nk;
    always_comb begin
        i_cur_nbrs = '0;
        cx = int'(o_cur_x);
        cy = int'(o_cur_y);
        nk = 0;
        i_cur_cell = mem[o_bank_sel][cy * W + cx];
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    i_cur_nbrs[nk] =
                        mem[o_bank_sel][((cy + dy + H) % H) * W + (cx + dx + W) % W];
                    nk = nk + 1;
                end
            end
        end
    end

    // Monitor: write/done/ack counts and protocol violations
    int wr = 0, dn = 0, acks = 0, bad = 0;
    logic prev_sw = 1'b0;
    int wr_q[$];

    always @(negedge clk) begin
        if (o_nxt_w_en && (!o_busy || o_gen_done || !prev_sw)) bad <= bad + 1;
        if (!o_busy && (o_cur_x != 0 || o_cur_y != 0 || o_cur_w_en)) bad <= bad + 1;
        if (o_gen_done && (o_cur_x != 0 || o_cur_y != 0 || o_cur_w_en)) bad <= bad + 1;
        prev_sw <= o_busy && !o_cur_w_en && !o_gen_done;
        if (o_nxt_w_en) wr <= wr + 1;
        if (o_gen_done) begin
            dn <= dn + 1;
            wr_q.push_back(wr);
        end
        if (o_edit_ack) acks <= acks + 1;
    end

    // Reference field and expectations
    logic ref_f [NC];
    logic exp_bs = 1'b0;
    int   exp_gc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NC; i++) ref_f[i] = 1'b0;
        exp_bs = 1'b0;
        exp_gc = 0;
    endtask

    task automatic ref_step();
        logic t [NC];
        int c;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            c += int'(ref_f[((y + dy + H) % H) * W + (x + dx + W) % W]);
                t[y * W + x] = ref_f[y * W + x] ? SM[c] : BM[c];
            end
        end
        for (int i = 0; i < NC; i++) ref_f[i] = t[i];
        exp_bs = ~exp_bs;
        exp_gc++;
    endtask

    function automatic int field_diff();
        int d = 0;
        for (int i = 0; i < NC; i++)
            if (mem[exp_bs][i] !== ref_f[i]) d++;
        return d;
    endfunction

    function automatic int live_cnt();
        int d = 0;
        for (int i = 0; i < NC; i++)
            if (mem[exp_bs][i] === 1'b1) d++;
        return d;
    endfunction

    // Called at posedge+1 with the DUT idle
    task automatic do_edit(input int x, input int y, input logic v);
        bit got = 0;
        i_edit_x = 3'(x);
        i_edit_y = 3'(y);
        i_edit_val = v;
        i_edit_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_edit_ack) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_edit_req = 1'b0;
        if (got) ref_f[y * W + x] = v;
        else chk("edit_timeout", 0, 1);
    endtask

    task automatic do_gen(input string tag);
        bit got = 0;
        int lat = -1;
        int w0;
        w0 = wr;
        i_step = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_gen_done) begin
                got = 1;
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
            i_step = 1'b0;
        end
        @(posedge clk);
        #1;
        i_step = 1'b0;
        chk({tag, "_latency"}, lat, 66);
        ref_step();
        chk({tag, "_bank_sel"}, int'(o_bank_sel), int'(exp_bs));
        chk({tag, "_gen_cnt"}, int'(o_gen_cnt), exp_gc);
        chk({tag, "_writes"}, wr - w0, 64);
        chk({tag, "_field"}, field_diff(), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, a0, w0, d0, k;
        int t[3];
        ref_clear();

        // Reset values
        #3;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_bank_sel", int'(o_bank_sel), 0);
        chk("rst_gen_cnt", int'(o_gen_cnt), 0);
        chk("rst_nxt_w_en", int'(o_nxt_w_en), 0);
        chk("rst_ack_done", int'({o_edit_ack, o_gen_done}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Blinker
        do_edit(3, 2, 1'b1);
        do_edit(3, 3, 1'b1);
        do_edit(3, 4, 1'b1);
        do_gen("blinker");
        chk("blinker_live", live_cnt(), 3);
        chk("blinker_row", int'(mem[1][3 * W + 2] & mem[1][3 * W + 3] & mem[1][3 * W + 4]), 1);

        // Still life block
        do_reset();
        do_edit(1, 1, 1'b1);
        do_edit(2, 1, 1'b1);
        do_edit(1, 2, 1'b1);
        do_edit(2, 2, 1'b1);
        do_gen("block1");
        do_gen("block2");
        chk("block_live", live_cnt(), 4);
        chk("block_bank_sel", int'(o_bank_sel), 0);
        chk("block_gen_cnt", int'(o_gen_cnt), 2);

        // Step and edit in the same cycle
        a0 = acks;
        w0 = wr;
        d0 = dn;
        first = -1;
        i_edit_x = 3'd5;
        i_edit_y = 3'd6;
        i_edit_val = 1'b1;
        i_step = 1'b1;
        i_edit_req = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_edit_ack) begin
                first = n;
                break;
            end
            @(posedge clk);
            #1;
            i_step = 1'b0;
        end
        @(posedge clk);
        #1;
        i_step = 1'b0;
        i_edit_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("conflict_ack_cycle", first, 68);
        chk("conflict_ack_once", acks - a0, 1);
        chk("conflict_done", dn - d0, 1);
        chk("conflict_writes", wr - w0, 64);
        ref_step();
        ref_f[6 * W + 5] = 1'b1;
        chk("conflict_field", field_diff(), 0);

        // Free run for three generations
        w0 = wr;
        k = 0;
        i_run = 1'b1;
        for (int n = 0; n < 400 && k < 3; n++) begin
            @(negedge clk);
            if (o_gen_done) begin
                t[k] = n;
                k++;
                if (k == 3) i_run = 1'b0;
            end
        end
        i_run = 1'b0;
        @(posedge clk);
        #1;
        chk("run_gens", k, 3);
        if (k == 3) begin
            chk("run_first", t[0], 66);
            chk("run_gap1", t[1] - t[0], 67);
            chk("run_gap2", t[2] - t[1], 67);
            chk("run_wr1", wr_q[wr_q.size() - 3] - w0, 64);
            chk("run_wr2", wr_q[wr_q.size() - 2] - wr_q[wr_q.size() - 3], 64);
            chk("run_wr3", wr_q[wr_q.size() - 1] - wr_q[wr_q.size() - 2], 64);
        end
        repeat (3) ref_step();
        chk("run_gen_cnt", int'(o_gen_cnt), exp_gc);
        chk("run_field", field_diff(), 0);

        // Random soup
        for (int i = 0; i < 24; i++)
            do_edit(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                    1'($urandom_range(0, 1)));
        do_gen("soup1");
        do_gen("soup2");
        do_gen("soup3");

        // Reset in the middle of a sweep
        i_step = 1'b1;
        @(posedge clk);
        #1;
        i_step = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("mid_busy", int'(o_busy), 1);
        chk("mid_scan", int'({o_cur_y, o_cur_x}), (3 << 3) | 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_bank_gen", int'({o_bank_sel, o_gen_cnt}), 0);
        chk("mid_rst_pulses", int'({o_nxt_w_en, o_gen_done, o_edit_ack, o_cur_w_en}), 0);
        ref_clear();
        w0 = wr;
        d0 = dn;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_no_writes", wr - w0, 0);
        chk("mid_no_done", dn - d0, 0);
        chk("mid_field", field_diff(), 0);

        // Corner cell dies
        do_edit(0, 0, 1'b1);
        do_gen("corner");
        chk("corner_live", live_cnt(), 0);

        @(negedge clk);
        chk("monitor_violations", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
